// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: computes a - b - bin.
// Ports:
//   a, b    : operand bits
//   bin     : borrow-in
//   diff    : difference bit
//   borrow  : borrow-out, set when a < b + bin
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, with a
// registered borrow chain through a single full_subtractor cell.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : request, honoured in IDLE or DONE
//   a_in, b_in  : minuend / subtrahend, captured on an accepted start
//   bin_in      : borrow-in to bit 0, captured on an accepted start
//   busy        : high while bits are being processed
//   done        : one-cycle completion pulse
//   diff_out    : (a - b - bin) mod 2^WIDTH, held until the next completion
//   borrow_out  : final borrow, held until the next completion
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow_q;

  logic             accept_c;
  logic             last_bit_c;
  logic             cell_diff_c;
  logic             cell_borrow_c;
  logic [WIDTH-1:0] res_nxt_c;

  // Single cell shared across all bit positions.
  full_subtractor u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .bin    (borrow_q),
    .diff   (cell_diff_c),
    .borrow (cell_borrow_c)
  );

  assign accept_c   = start && (state != S_SHIFT);
  assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));
  // New difference bit enters at the MSB; after WIDTH shifts bit i sits at i.
  assign res_nxt_c  = {cell_diff_c, res_sr[WIDTH-1:1]};

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow_q   <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_SHIFT);
      done  <= (state_nxt == S_DONE);
      if (accept_c) begin
        a_sr     <= a_in;
        b_sr     <= b_in;
        borrow_q <= bin_in;
        cnt      <= '0;
        res_sr   <= '0;
      end else if (state == S_SHIFT) begin
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        borrow_q <= cell_borrow_c;
        res_sr   <= res_nxt_c;
        cnt      <= cnt + CNT_W'(1);
        if (last_bit_c) begin
          diff_out   <= res_nxt_c;
          borrow_out <= cell_borrow_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;

  int tests;
  int failed;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and pulse start for exactly one rising edge.
  task automatic start_pulse(input logic [7:0] a, input logic [7:0] b, input logic bi);
    @(negedge clk);
    a_in = a; b_in = b; bin_in = bi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count falling edges until done (bounded); also counts busy cycles and
  // flags any diff_out change before done.
  task automatic wait_done(input logic [7:0] hold_val, output int lat, output int busy_cnt,
                           output logic moved, output logic both_high);
    lat = 0; busy_cnt = 0; moved = 1'b0; both_high = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (busy && done) both_high = 1'b1;
      if (!done) begin
        if (busy) busy_cnt++;
        if (diff_out !== hold_val) moved = 1'b1;
      end
    end while (!done && lat < 30);
  endtask

  // One complete run with a one-cycle start and full result checking.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] exp_d, input logic exp_bo);
    int lat, bc;
    logic moved, both;
    logic [7:0] prev;
    prev = diff_out;
    start_pulse(a, b, bi);
    wait_done(prev, lat, bc, moved, both);
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " busy cycles"}, 32'(bc), 32'd8);
    check({tag, " diff held while busy"}, 32'(moved), 32'd0);
    check({tag, " busy&done"}, 32'(both), 32'd0);
    check({tag, " diff"}, 32'(diff_out), 32'(exp_d));
    check({tag, " borrow"}, 32'(borrow_out), 32'(exp_bo));
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " diff held idle"}, 32'(diff_out), 32'(exp_d));
  endtask

  initial begin
    int lat, bc, dones, done_at;
    logic moved, both;
    tests = 0; failed = 0;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff_out), 32'd0);
    check("reset borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("5-3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    run_op("3-5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    run_op("0-0-1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run_op("FF-FF-1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("A5-5A", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0);

    // Start pulsed mid-run with new operands must be ignored.
    start_pulse(8'h05, 8'h03, 1'b0);
    dones = 0; done_at = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 3) begin
        a_in = 8'hFF; b_in = 8'h00; bin_in = 1'b0; start = 1'b1;
      end else if (i == 4) begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (done_at == 0) done_at = i;
        check("ignore diff", 32'(diff_out), 32'h02);
        check("ignore borrow", 32'(borrow_out), 32'd0);
      end
    end
    check("ignore done count", 32'(dones), 32'd1);
    check("ignore done time", 32'(done_at), 32'd9);

    // Back-to-back: start held high across DONE; operands change after accept.
    @(negedge clk);
    a_in = 8'hA5; b_in = 8'h5A; bin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a_in = 8'h10; b_in = 8'h01; bin_in = 1'b1;
    wait_done(8'h02, lat, bc, moved, both);
    check("b2b first latency", 32'(lat), 32'd9);
    check("b2b first diff", 32'(diff_out), 32'h4B);
    check("b2b first borrow", 32'(borrow_out), 32'd0);
    wait_done(8'h4B, lat, bc, moved, both);
    start = 1'b0;
    check("b2b second latency", 32'(lat), 32'd9);
    check("b2b no idle gap", 32'(bc), 32'd8);
    check("b2b first held", 32'(moved), 32'd0);
    check("b2b busy&done", 32'(both), 32'd0);
    check("b2b second diff", 32'(diff_out), 32'h0E);
    check("b2b second borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    check("b2b returns idle", 32'(busy), 32'd0);

    // Make borrow_out nonzero so the reset clear is observable.
    run_op("3-5 pre-reset", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);

    // Reset during the 4th shift cycle aborts the run.
    start_pulse(8'h12, 8'h34, 1'b0);
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff_out), 32'd0);
    check("abort borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; bc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) bc++;
    end
    check("post-reset no done", 32'(dones), 32'd0);
    check("post-reset no busy", 32'(bc), 32'd0);

    run_op("80-1 recover", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
